// File: rtl/lanectrl_seq_pkg.sv
// Shared types and helpers for the lane-controller delay-step sequencer.
package lanectrl_seq_pkg;
  localparam int   OFS_W  = 9;
  localparam logic SEL_RX = 1'b0;
  localparam logic SEL_TX = 1'b1;

  typedef enum logic [2:0] {
    S_IDLE, S_SETUP, S_MOVE, S_GAP, S_LOAD, S_HOLD, S_FIN
  } seq_state_e;

  // Clamp a tap offset to the symmetric range +/-lim.
  function automatic int ofs_sat(input int v, input int lim);
    if (v > lim) return lim;
    if (v < -lim) return -lim;
    return v;
  endfunction
endpackage

// File: rtl/lanectrl_dly_ofs_cnt.sv
// Signed saturating up/down tap-offset counter with synchronous clear.
module lanectrl_dly_ofs_cnt
  import lanectrl_seq_pkg::*;
#(
  parameter int W = OFS_W
) (
  input  logic         gclk,
  input  logic         grst_n,
  input  logic         step,
  input  logic         up,
  input  logic         clr,
  output logic [W-1:0] ofs
);
  localparam int LIM = (1 << (W - 1)) - 1;

  int cur, nxt;

  always_comb begin
    cur = int'($signed(ofs));
    nxt = cur;
    if (clr)       nxt = 0;
    else if (step) nxt = ofs_sat(up ? cur + 1 : cur - 1, LIM);
  end

  always_ff @(posedge gclk or negedge grst_n)
    if (!grst_n) ofs <= '0;
    else         ofs <= W'(nxt);
endmodule

// File: rtl/lanectrl_dly_step_sequencer.sv
// Turns training step/load requests into paused delay-line MOVE/LOAD pulses for one lane.
module lanectrl_dly_step_sequencer
  import lanectrl_seq_pkg::*;
#(
  parameter int PAUSE_SETUP = 4,
  parameter int MOVE_GAP    = 2,
  parameter int PAUSE_HOLD  = 4,
  parameter int OFS_W       = 9
) (
  input  logic             FAB_CLK,
  input  logic             RESET_N,
  input  logic             REQ_VALID,
  output logic             REQ_READY,
  input  logic             REQ_LOAD,
  input  logic             REQ_SEL,
  input  logic             REQ_DIR,
  input  logic [7:0]       REQ_CNT,
  output logic             DONE,
  output logic             ERR,
  output logic [7:0]       MOVED,
  output logic [OFS_W-1:0] RX_OFS,
  output logic [OFS_W-1:0] TX_OFS,
  output logic             DELAY_LINE_SEL,
  output logic             DELAY_LINE_DIRECTION,
  output logic             DELAY_LINE_LOAD,
  output logic             DELAY_LINE_MOVE,
  output logic             HS_IO_CLK_PAUSE,
  input  logic             RX_DELAY_LINE_OUT_OF_RANGE,
  input  logic             TX_DELAY_LINE_OUT_OF_RANGE
);
  localparam logic [7:0] SETUP_W = 8'(PAUSE_SETUP);
  localparam logic [7:0] GAP_W   = 8'(MOVE_GAP - 1);
  localparam logic [7:0] HOLD_W  = 8'(PAUSE_HOLD - 1);

  seq_state_e               state;
  logic [7:0]               wcnt, cnt_q;
  logic                     load_q, oor_sel, last_move;
  logic [1:0][OFS_W-1:0]    ofs;

  assign oor_sel   = DELAY_LINE_SEL ? TX_DELAY_LINE_OUT_OF_RANGE : RX_DELAY_LINE_OUT_OF_RANGE;
  assign last_move = ({1'b0, MOVED} + 9'd1) == {1'b0, cnt_q};

  always_ff @(posedge FAB_CLK or negedge RESET_N)
    if (!RESET_N) begin
      state                <= S_IDLE;
      REQ_READY            <= 1'b1;
      DONE                 <= 1'b0;
      ERR                  <= 1'b0;
      MOVED                <= '0;
      DELAY_LINE_SEL       <= 1'b0;
      DELAY_LINE_DIRECTION <= 1'b0;
      DELAY_LINE_LOAD      <= 1'b0;
      DELAY_LINE_MOVE      <= 1'b0;
      HS_IO_CLK_PAUSE      <= 1'b0;
      wcnt                 <= '0;
      cnt_q                <= '0;
      load_q               <= 1'b0;
    end else begin
      DONE            <= 1'b0;
      DELAY_LINE_MOVE <= 1'b0;
      DELAY_LINE_LOAD <= 1'b0;
      case (state)
        S_IDLE: if (REQ_VALID) begin
          DELAY_LINE_SEL       <= REQ_SEL;
          DELAY_LINE_DIRECTION <= REQ_DIR;
          load_q               <= REQ_LOAD;
          cnt_q                <= REQ_CNT;
          MOVED                <= '0;
          ERR                  <= 1'b0;
          REQ_READY            <= 1'b0;
          if (!REQ_LOAD && REQ_CNT == 8'd0) begin
            state <= S_FIN;
            DONE  <= 1'b1;
          end else begin
            state           <= S_SETUP;
            HS_IO_CLK_PAUSE <= 1'b1;
            wcnt            <= SETUP_W;
          end
        end
        // Final SETUP cycle samples the flag so an out-of-range line never sees a MOVE.
        S_SETUP: begin
          if (oor_sel && !load_q) ERR <= 1'b1;
          if (wcnt != 8'd0) wcnt <= wcnt - 8'd1;
          else if (load_q) begin
            state           <= S_LOAD;
            DELAY_LINE_LOAD <= 1'b1;
          end else if (ERR || oor_sel) begin
            state <= S_HOLD;
            wcnt  <= HOLD_W;
          end else begin
            state           <= S_MOVE;
            DELAY_LINE_MOVE <= 1'b1;
          end
        end
        S_MOVE: begin
          MOVED <= MOVED + 8'd1;
          state <= last_move ? S_HOLD : S_GAP;
          wcnt  <= last_move ? HOLD_W : GAP_W;
        end
        S_GAP: begin
          if (oor_sel) begin
            ERR   <= 1'b1;
            state <= S_HOLD;
            wcnt  <= HOLD_W;
          end else if (wcnt != 8'd0) wcnt <= wcnt - 8'd1;
          else begin
            state           <= S_MOVE;
            DELAY_LINE_MOVE <= 1'b1;
          end
        end
        S_LOAD: begin
          state <= S_HOLD;
          wcnt  <= HOLD_W;
        end
        S_HOLD: begin
          if (wcnt != 8'd0) wcnt <= wcnt - 8'd1;
          else begin
            state           <= S_FIN;
            HS_IO_CLK_PAUSE <= 1'b0;
            DONE            <= 1'b1;
          end
        end
        S_FIN: begin
          state     <= S_IDLE;
          REQ_READY <= 1'b1;
        end
        default: state <= S_IDLE;
      endcase
    end

  for (genvar l = 0; l < 2; l++) begin : g_line
    lanectrl_dly_ofs_cnt #(.W(OFS_W)) u_ofs (
      .gclk   (FAB_CLK),
      .grst_n (RESET_N),
      .step   (state == S_MOVE && DELAY_LINE_SEL == 1'(l)),
      .up     (DELAY_LINE_DIRECTION),
      .clr    (state == S_LOAD && DELAY_LINE_SEL == 1'(l)),
      .ofs    (ofs[l])
    );
  end

  assign RX_OFS = ofs[SEL_RX];
  assign TX_OFS = ofs[SEL_TX];
endmodule
